// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture block: FSM states and duty-width derivation.
package pwm_pkg;

   localparam int unsigned STEPS_DEF = 256;

   // Number of quotient bits needed to express a duty in [0, steps-1].
   function automatic int unsigned duty_width(input int unsigned steps);
      return $clog2(steps);
   endfunction

   typedef enum logic [0:0] {
      StIdle,
      StMeasure
   } meas_state_e;

endpackage

// File: rtl/serial_div.sv
// Restoring unsigned divider producing one quotient bit per cycle.
// The caller guarantees num_i >> W_QUO < den_i, so the quotient fits in W_QUO bits.
module serial_div #(
   parameter int unsigned W_NUM = 24,
   parameter int unsigned W_DEN = 16,
   parameter int unsigned W_QUO = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [W_NUM-1:0] num_i,
   input  logic [W_DEN-1:0] den_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [W_QUO-1:0] quot_o
);

   localparam int unsigned W_STEP = $clog2(W_QUO + 1);

   logic [W_DEN:0]   rem_q, rem_d;
   logic [W_QUO-1:0] nlo_q, nlo_d;
   logic [W_QUO-1:0] quo_q, quo_d;
   logic [W_DEN-1:0] den_q, den_d;
   logic [W_STEP-1:0] step_q, step_d;
   logic             busy_q, busy_d;

   logic [W_DEN:0]   trial;
   logic             fits;
   logic [W_QUO-1:0] quo_next;
   logic             last_step;

   // Trial subtraction, next-state and handshake outputs
   always_comb begin
      trial     = {rem_q[W_DEN-1:0], nlo_q[W_QUO-1]};
      fits      = (trial >= {1'b0, den_q});
      quo_next  = (quo_q << 1) | W_QUO'(fits);
      last_step = (step_q == W_STEP'(W_QUO - 1));

      rem_d  = rem_q;
      nlo_d  = nlo_q;
      quo_d  = quo_q;
      den_d  = den_q;
      step_d = step_q;
      busy_d = busy_q;

      if (busy_q) begin
         rem_d  = fits ? (trial - {1'b0, den_q}) : trial;
         nlo_d  = nlo_q << 1;
         quo_d  = quo_next;
         step_d = step_q + 1'b1;
         if (last_step) begin
            busy_d = 1'b0;
         end
      end else if (start_i) begin
         // Upper part of the numerator is already below the divisor
         rem_d  = (W_DEN + 1)'(num_i >> W_QUO);
         nlo_d  = num_i[W_QUO-1:0];
         den_d  = den_i;
         quo_d  = '0;
         step_d = '0;
         busy_d = 1'b1;
      end

      busy_o = busy_q;
      done_o = busy_q & last_step;
      quot_o = quo_next;
   end

   // Divider state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_q  <= '0;
         nlo_q  <= '0;
         quo_q  <= '0;
         den_q  <= '0;
         step_q <= '0;
         busy_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         nlo_q  <= nlo_d;
         quo_q  <= quo_d;
         den_q  <= den_d;
         step_q <= step_d;
         busy_q <= busy_d;
      end
   end

endmodule

// File: rtl/pwm_capture.sv
// Measures high time, period and scaled duty of an asynchronous PWM input.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter  int unsigned STEPS       = STEPS_DEF,
   parameter  int unsigned W_CNT       = 16,
   parameter  int unsigned SYNC_STAGES = 2,
   localparam int unsigned W_DUTY      = duty_width(STEPS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pwm_in,
   output logic [W_CNT-1:0]  high_o,
   output logic [W_CNT-1:0]  period_o,
   output logic [W_DUTY-1:0] duty_o,
   output logic              valid_o,
   output logic              overrun_o,
   output logic              stuck_o,
   output logic              stuck_lvl_o
);

   localparam logic [W_CNT-1:0] CNT_MAX = '1;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   dly_q, dly_d;
   logic                   lvl, rise, fall;

   meas_state_e            state_q, state_d;
   logic [W_CNT-1:0]       cnt_q, cnt_d;
   logic [W_CNT-1:0]       hcnt_q, hcnt_d;
   logic                   fall_seen_q, fall_seen_d;
   logic [W_CNT-1:0]       lat_high_q, lat_high_d;
   logic [W_CNT-1:0]       lat_per_q, lat_per_d;
   logic [W_CNT-1:0]       per_now;

   logic [W_CNT-1:0]       high_q, high_d;
   logic [W_CNT-1:0]       period_q, period_d;
   logic [W_DUTY-1:0]      duty_q, duty_d;
   logic                   valid_q, valid_d;
   logic                   overrun_q, overrun_d;
   logic                   stuck_q, stuck_d;
   logic                   stuck_lvl_q, stuck_lvl_d;

   logic                   div_start, div_busy, div_done;
   logic [W_DUTY-1:0]      div_quot;

   // Synchronizer, edge detection and measurement FSM
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], pwm_in};
      lvl    = sync_q[SYNC_STAGES-1];
      dly_d  = lvl;
      rise   = lvl & ~dly_q;
      fall   = ~lvl & dly_q;
      // A rise exactly at the timeout count would overflow; saturate instead
      per_now = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;

      state_d     = state_q;
      cnt_d       = cnt_q;
      hcnt_d      = hcnt_q;
      fall_seen_d = fall_seen_q;
      lat_high_d  = lat_high_q;
      lat_per_d   = lat_per_q;
      overrun_d   = 1'b0;
      stuck_d     = stuck_q;
      stuck_lvl_d = stuck_lvl_q;
      div_start   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (rise) begin
               cnt_d       = '0;
               hcnt_d      = '0;
               fall_seen_d = 1'b0;
               stuck_d     = 1'b0;
               state_d     = StMeasure;
            end
         end
         StMeasure: begin
            if (rise) begin
               if (!div_busy) begin
                  div_start  = 1'b1;
                  lat_high_d = hcnt_q;
                  lat_per_d  = per_now;
               end else begin
                  overrun_d = 1'b1;
               end
               cnt_d       = '0;
               hcnt_d      = '0;
               fall_seen_d = 1'b0;
            end else if (cnt_q == CNT_MAX) begin
               stuck_d     = 1'b1;
               stuck_lvl_d = lvl;
               state_d     = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
               // Delayed level is used so the rise cycle itself counts as high
               if (dly_q && !fall_seen_q) begin
                  hcnt_d = hcnt_q + 1'b1;
               end
               if (fall) begin
                  fall_seen_d = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   serial_div #(
      .W_NUM (W_CNT + W_DUTY),
      .W_DEN (W_CNT),
      .W_QUO (W_DUTY)
   ) u_div (
      .clk     (clk),
      .rst     (rst),
      .start_i (div_start),
      .num_i   ({hcnt_q, {W_DUTY{1'b0}}}),
      .den_i   (per_now),
      .busy_o  (div_busy),
      .done_o  (div_done),
      .quot_o  (div_quot)
   );

   // Result registers update together when the divider finishes
   always_comb begin
      high_d   = high_q;
      period_d = period_q;
      duty_d   = duty_q;
      valid_d  = 1'b0;
      if (div_done) begin
         high_d   = lat_high_q;
         period_d = lat_per_q;
         duty_d   = div_quot;
         valid_d  = 1'b1;
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q      <= '0;
         dly_q       <= 1'b0;
         state_q     <= StIdle;
         cnt_q       <= '0;
         hcnt_q      <= '0;
         fall_seen_q <= 1'b0;
         lat_high_q  <= '0;
         lat_per_q   <= '0;
         high_q      <= '0;
         period_q    <= '0;
         duty_q      <= '0;
         valid_q     <= 1'b0;
         overrun_q   <= 1'b0;
         stuck_q     <= 1'b0;
         stuck_lvl_q <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         dly_q       <= dly_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hcnt_q      <= hcnt_d;
         fall_seen_q <= fall_seen_d;
         lat_high_q  <= lat_high_d;
         lat_per_q   <= lat_per_d;
         high_q      <= high_d;
         period_q    <= period_d;
         duty_q      <= duty_d;
         valid_q     <= valid_d;
         overrun_q   <= overrun_d;
         stuck_q     <= stuck_d;
         stuck_lvl_q <= stuck_lvl_d;
      end
   end

   assign high_o      = high_q;
   assign period_o    = period_q;
   assign duty_o      = duty_q;
   assign valid_o     = valid_q;
   assign overrun_o   = overrun_q;
   assign stuck_o     = stuck_q;
   assign stuck_lvl_o = stuck_lvl_q;

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform and reports its high time, its period and its duty cycle scaled to `STEPS` levels. It is the receive-side counterpart of the triangle-carrier PWM generator. It closes the loop in simulation, where the generator output is fed back and checked, and in designs that consume an external PWM command. The duty cycle is computed with a serial restoring divider, so no wide combinational divide is needed.

## Interface
Parameters:
- `STEPS`, 256: duty resolution; `W_DUTY = $clog2(STEPS)`.
- `W_CNT`, 16: width of the high-time and period counters.
- `SYNC_STAGES`, 2: depth of the input synchronizer (≥2).

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `pwm_in`  in  1  asynchronous PWM input.
- `high_o`  out  `W_CNT`  high time of the last complete period, in `clk` cycles.
- `period_o`  out  `W_CNT`  last complete period, in `clk` cycles.
- `duty_o`  out  `W_DUTY`  floor(`high_o`·`STEPS`/`period_o`).
- `valid_o`  out  1  one-cycle pulse; all three result outputs update in this same cycle.
- `overrun_o`  out  1  one-cycle pulse; a measurement was dropped because the divider was busy.
- `stuck_o`  out  1  level; no edge seen for 2^`W_CNT`−1 cycles.
- `stuck_lvl_o`  out  1  synchronized input level at the moment `stuck_o` was set.

## Operation
- The input passes through the `SYNC_STAGES` flop synchronizer, then one delay flop for edge detection, giving `rise` and `fall` single-cycle strobes.
- Measurement FSM states:
  - IDLE: wait for `rise`; on it, clear both counters and go to MEASURE.
  - MEASURE: the period counter increments every cycle. The high counter increments while the synchronized level is 1 and no `fall` has been seen in this period.
  - On `rise` in MEASURE: latch `period = cnt+1` and `high`. If the divider is idle, start it; otherwise pulse `overrun_o` and discard the sample. Counters restart at 0 in the same cycle.
- Divider: restoring, unsigned. Numerator is `high`·`STEPS`, a shift by `W_DUTY` into a `W_CNT+W_DUTY`-bit value. Denominator is `period`. It produces `W_DUTY` quotient bits, one per cycle. Because `high` < `period`, the quotient is always ≤ `STEPS`−1 and no clamp is needed.
- On divider completion: register `duty_o`, `high_o` and `period_o` together and pulse `valid_o`.
- Timeout: if the period counter reaches 2^`W_CNT`−1:
  - set `stuck_o`=1 and `stuck_lvl_o` = synchronized level;
  - go to IDLE;
  - result outputs hold their last values.
- `stuck_o` clears on the next `rise`. No `valid_o` is produced until one full period has been measured after that.
- A sample with `high`=0 is reported normally, with duty 0. This case arises from a rise immediately after the previous rise, or from a glitch too short to be synchronized.
- Simultaneous timeout and `rise`: `rise` wins and the sample is measured.

## Timing
- Reset values: all outputs 0; FSM in IDLE; divider idle; synchronizer cleared to 0.
- Edge latency: an input transition produces `rise`/`fall` `SYNC_STAGES`+1 clock edges later. Period and high measurements are exact in cycles for a clean input.
- Result latency: `valid_o` asserts `W_DUTY`+1 cycles after the `rise` that closes the period. That is 9 cycles at `STEPS`=256.
- Minimum period without overrun: `W_DUTY`+1 cycles.
- Reset asserted mid-divide: the result is discarded and no `valid_o` is issued. After release, the first valid needs two `rise` events.

## Structure
- Shared package `pwm_pkg`:
  - FSM state enum (IDLE, MEASURE);
  - the `STEPS` default;
  - `W_DUTY` derivation.
- One sub-module, `serial_div`. Parameters: numerator and denominator widths, and the number of quotient bits. Handshake: `start`/`busy`/`done`, with quotient output.

## Test plan
- `pwm_in` high 25 / low 75 cycles, repeating → `high_o`=25, `period_o`=100, `duty_o`=64, one `valid_o` per period, 9 cycles after each rise.
- Drive with the triangle-carrier PWM generator, carrier `STEPS`=256, `MAIN_DIV`=4, constant compare value 128 → `duty_o` within ±1 of 128 every period.
- High 1 / period 1000 → `duty_o`=0, `high_o`=1. High 999 / period 1000 → `duty_o`=255.
- Period 4 (high 2), shorter than divider latency → `overrun_o` pulses; every accepted sample reports `duty_o`=128.
- Hold `pwm_in`=1 for 70000 cycles → `stuck_o`=1, `stuck_lvl_o`=1, last results held. Resume 50% PWM → `stuck_o` clears at the first rise, `valid_o` after the next period.
- Assert `rst` 3 cycles after a closing rise (divider mid-run) → no `valid_o`, all outputs 0, and the first valid appears after two rises post-release.
